// File: rtl/dino_pkg.sv
// Shared FSM state, sprite encoding and default constants for the obstacle scheduler.
package dino_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    KIND_CACTUS1 = 2'd0,
    KIND_CACTUS2 = 2'd1,
    KIND_CACTUS3 = 2'd2,
    KIND_NONE    = 2'd3
  } kind_e;

  localparam int DEF_SPAWN_X  = 640;
  localparam int DEF_DINO_X   = 100;
  localparam int DEF_MIN_GAP  = 40;
  localparam int DEF_GAP_STEP = 4;
  localparam int DEF_SPEED    = 2;

  localparam int XPOS_W  = 10;
  localparam int KIND_W  = 2;
  localparam int GAP_W   = 8;
  localparam int SPEED_W = 4;
  localparam int COUNT_W = 8;

  // Spacing, in ticks, before the next obstacle may appear.
  function automatic logic [GAP_W-1:0] gap_reload(input int min_gap, input int gap_step,
                                                  input logic [4:0] rnd);
    return GAP_W'(min_gap + gap_step * int'(rnd));
  endfunction

endpackage

// File: rtl/obstacle_slot.sv
// One obstacle slot: spawn, scroll left by the current speed, retire at the edge,
// and flag the tick on which it crosses the runner column.
module obstacle_slot import dino_pkg::*; #(
  parameter int SPAWN_X = DEF_SPAWN_X,
  parameter int DINO_X  = DEF_DINO_X
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear_i,
  input  logic               step_i,
  input  logic               spawn_i,
  input  logic [KIND_W-1:0]  kind_i,
  input  logic [SPEED_W-1:0] speed_i,
  output logic               valid_o,
  output logic [XPOS_W-1:0]  xpos_o,
  output logic [KIND_W-1:0]  kind_o,
  output logic               pass_o
);

  localparam logic [XPOS_W-1:0] SPAWN_COL = XPOS_W'(SPAWN_X);
  localparam logic [XPOS_W-1:0] DINO_COL  = XPOS_W'(DINO_X);

  logic              valid_q, valid_d;
  logic [XPOS_W-1:0] xpos_q, xpos_d;
  logic [KIND_W-1:0] kind_q, kind_d;
  logic [XPOS_W-1:0] speed_ext, xpos_next;
  logic              retire;

  assign speed_ext = XPOS_W'(speed_i);
  assign xpos_next = xpos_q - speed_ext;
  assign retire    = valid_q && (xpos_q < speed_ext);
  assign pass_o    = step_i && valid_q && !retire &&
                     (xpos_q >= DINO_COL) && (xpos_next < DINO_COL);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    valid_d = valid_q;
    xpos_d  = xpos_q;
    kind_d  = kind_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (step_i) begin
      if (spawn_i) begin
        valid_d = 1'b1;
        xpos_d  = SPAWN_COL;
        kind_d  = kind_i;
      end else if (retire) begin
        valid_d = 1'b0;
      end else if (valid_q) begin
        xpos_d = xpos_next;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      xpos_q  <= '0;
      kind_q  <= '0;
    end else begin
      valid_q <= valid_d;
      xpos_q  <= xpos_d;
      kind_q  <= kind_d;
    end
  end

  assign valid_o = valid_q;
  assign xpos_o  = xpos_q;
  assign kind_o  = kind_q;

endmodule

// File: rtl/obstacle_scheduler.sv
// Obstacle spawner/scroller for the runner game: FSM, spawn spacing and pass scoring.
// Optional macro OBSTACLE_SPEEDUP_EN raises scroll speed every 8 obstacles passed.
module obstacle_scheduler import dino_pkg::*; #(
  parameter int NUM_SLOTS = 3,
  parameter int SPAWN_X   = DEF_SPAWN_X,
  parameter int DINO_X    = DEF_DINO_X,
  parameter int MIN_GAP   = DEF_MIN_GAP,
  parameter int GAP_STEP  = DEF_GAP_STEP,
  parameter int SPEED     = DEF_SPEED
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        tick,
  input  logic                        start,
  input  logic                        halt,
  input  logic [4:0]                  random,
  output logic [NUM_SLOTS-1:0]        valid,
  output logic [XPOS_W*NUM_SLOTS-1:0] xpos,
  output logic [KIND_W*NUM_SLOTS-1:0] kind,
  output logic                        pass_pulse,
  output logic [COUNT_W-1:0]          pass_count,
  output logic                        running
);

  state_e               state_q, state_d;
  logic [GAP_W-1:0]     gap_q, gap_d, gap_dec;
  logic [COUNT_W-1:0]   pass_count_q, pass_count_d;
  logic [COUNT_W:0]     pass_sum;
  logic                 pass_pulse_q, running_q;
  logic                 step, restart, spawn_due;
  logic [NUM_SLOTS-1:0] slot_valid, slot_pass, first_free, spawn_vec;
  logic [SPEED_W-1:0]   speed;

  always_comb begin
    state_d = state_q;
    restart = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_HALTED: begin
        if (start && !halt) begin
          state_d = ST_RUN;
          restart = 1'b1;
        end
      end
      ST_RUN:  if (halt) state_d = ST_HALTED;
      default: state_d = ST_IDLE;
    endcase
  end

  // halt wins over a coincident tick, so a frozen frame never advances.
  assign step = (state_q == ST_RUN) && !halt && tick;

  // The gap is judged after this tick's decrement: a reload of N spawns N ticks later.
  always_comb begin
    gap_dec    = (gap_q == '0) ? '0 : gap_q - 1'b1;
    first_free = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!slot_valid[i] && (first_free == '0)) first_free[i] = 1'b1;
    end
    spawn_due = step && (gap_dec == '0) && (first_free != '0);
    spawn_vec = spawn_due ? first_free : '0;

    gap_d = gap_q;
    if (restart)   gap_d = '0;
    else if (step) gap_d = spawn_due ? gap_reload(MIN_GAP, GAP_STEP, random) : gap_dec;
  end

  always_comb begin
    pass_sum = {1'b0, pass_count_q};
    for (int i = 0; i < NUM_SLOTS; i++) begin
      pass_sum = pass_sum + (COUNT_W+1)'(slot_pass[i]);
    end
    pass_count_d = pass_sum[COUNT_W] ? '1 : pass_sum[COUNT_W-1:0];
    if (restart) pass_count_d = '0;
  end

`ifdef OBSTACLE_SPEEDUP_EN
  localparam logic [SPEED_W-1:0] SPEED_BASE = SPEED_W'(SPEED);
  localparam logic [SPEED_W-1:0] SPEED_MAX  = SPEED_W'(SPEED + 3);

  logic [SPEED_W-1:0] speed_q, speed_d;

  always_comb begin
    speed_d = speed_q;
    if (restart) begin
      speed_d = SPEED_BASE;
    end else if ((pass_count_d[COUNT_W-1:3] != pass_count_q[COUNT_W-1:3]) &&
                 (speed_q < SPEED_MAX)) begin
      speed_d = speed_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) speed_q <= SPEED_BASE;
    else       speed_q <= speed_d;
  end

  assign speed = speed_q;
`else
  assign speed = SPEED_W'(SPEED);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      gap_q        <= '0;
      pass_count_q <= '0;
      pass_pulse_q <= 1'b0;
      running_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      gap_q        <= gap_d;
      pass_count_q <= pass_count_d;
      pass_pulse_q <= |slot_pass;
      running_q    <= (state_d == ST_RUN);
    end
  end

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    obstacle_slot #(
      .SPAWN_X (SPAWN_X),
      .DINO_X  (DINO_X)
    ) u_slot (
      .clk     (clk),
      .reset   (reset),
      .clear_i (restart),
      .step_i  (step),
      .spawn_i (spawn_vec[g]),
      .kind_i  (random[1:0]),
      .speed_i (speed),
      .valid_o (slot_valid[g]),
      .xpos_o  (xpos[g*XPOS_W +: XPOS_W]),
      .kind_o  (kind[g*KIND_W +: KIND_W]),
      .pass_o  (slot_pass[g])
    );
  end

  assign valid      = slot_valid;
  assign pass_pulse = pass_pulse_q;
  assign pass_count = pass_count_q;
  assign running    = running_q;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Self-checking bench for obstacle_scheduler: directed scenarios plus random traffic
// compared cycle by cycle against a tick-indexed behavioural model.
module tb_obstacle_scheduler;
  import dino_pkg::*;

  localparam int NS = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             tick = 1'b0, start = 1'b0, halt = 1'b0;
  logic [4:0]       random = '0;
  logic [NS-1:0]    valid;
  logic [10*NS-1:0] xpos;
  logic [2*NS-1:0]  kind;
  logic             pass_pulse;
  logic [7:0]       pass_count;
  logic             running;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  obstacle_scheduler dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .start      (start),
    .halt       (halt),
    .random     (random),
    .valid      (valid),
    .xpos       (xpos),
    .kind       (kind),
    .pass_pulse (pass_pulse),
    .pass_count (pass_count),
    .running    (running)
  );

  // Model: a spawn is allowed once `spacing` ticks have elapsed since the last one.
  typedef enum {M_IDLE, M_RUN, M_HALTED} mstate_t;
  mstate_t m_state;
  bit      m_valid [NS];
  int      m_xpos  [NS];
  int      m_kind  [NS];
  int      m_count, m_tick_idx, m_last_spawn, m_spacing;
  bit      m_pulse;

  function automatic int m_speed();
`ifdef OBSTACLE_SPEEDUP_EN
    return DEF_SPEED + ((m_count / 8 > 3) ? 3 : m_count / 8);
`else
    return DEF_SPEED;
`endif
  endfunction

  task automatic model_reset();
    m_state = M_IDLE;
    foreach (m_valid[i]) begin m_valid[i] = 0; m_xpos[i] = 0; m_kind[i] = 0; end
    m_count = 0; m_pulse = 0; m_tick_idx = 0; m_last_spawn = -1000; m_spacing = 0;
  endtask

  task automatic model_tick(input logic [4:0] r);
    int spd, free, npass;
    spd = m_speed(); free = -1; npass = 0;
    m_tick_idx++;
    for (int i = NS - 1; i >= 0; i--) if (!m_valid[i]) free = i;
    for (int i = 0; i < NS; i++) begin
      if (m_valid[i]) begin
        if (m_xpos[i] < spd) m_valid[i] = 0;
        else begin
          if (m_xpos[i] >= DEF_DINO_X && m_xpos[i] - spd < DEF_DINO_X) npass++;
          m_xpos[i] -= spd;
        end
      end
    end
    if (free >= 0 && m_tick_idx - m_last_spawn >= m_spacing) begin
      m_valid[free] = 1; m_xpos[free] = DEF_SPAWN_X; m_kind[free] = int'(r[1:0]);
      m_last_spawn = m_tick_idx; m_spacing = DEF_MIN_GAP + DEF_GAP_STEP * int'(r);
    end
    m_count = (m_count + npass > 255) ? 255 : m_count + npass;
    m_pulse = (npass > 0);
  endtask

  task automatic model_clock(input logic t, input logic s, input logic h, input logic [4:0] r);
    m_pulse = 0;
    case (m_state)
      M_RUN: if (h) m_state = M_HALTED; else if (t) model_tick(r);
      default: if (s && !h) begin
        m_state = M_RUN;
        foreach (m_valid[i]) m_valid[i] = 0;
        m_count = 0; m_tick_idx = 0; m_last_spawn = -1000; m_spacing = 0;
      end
    endcase
  endtask

  task automatic compare_model(input string tag);
    for (int i = 0; i < NS; i++) begin
      vectors++;
      if (valid[i] !== m_valid[i] || xpos[i*10 +: 10] !== 10'(m_xpos[i]) ||
          kind[i*2 +: 2] !== 2'(m_kind[i])) begin
        miscompares++;
        $display("FAIL %s slot%0d: got v=%0b x=%0d k=%0d, expected v=%0b x=%0d k=%0d", tag, i,
                 valid[i], xpos[i*10 +: 10], kind[i*2 +: 2], m_valid[i], m_xpos[i], m_kind[i]);
      end
    end
    vectors++;
    if (pass_pulse !== m_pulse || pass_count !== 8'(m_count) || running !== (m_state == M_RUN)) begin
      miscompares++;
      $display("FAIL %s status: got pulse=%0b cnt=%0d run=%0b, expected pulse=%0b cnt=%0d run=%0b",
               tag, pass_pulse, pass_count, running, m_pulse, m_count, m_state == M_RUN);
    end
  endtask

  task automatic apply_cycle(input logic t, input logic s, input logic h, input logic [4:0] r,
                             input string tag);
    tick = t; start = s; halt = h; random = r;
    @(posedge clk);
    model_clock(t, s, h, r);
    #1;
    compare_model(tag);
  endtask

  task automatic restart_run();
    apply_cycle(1'b0, 1'b0, 1'b1, 5'd0, "restart_halt");
    apply_cycle(1'b0, 1'b1, 1'b0, 5'd0, "restart_start");
  endtask

  task automatic test_reset();
    model_reset();
    #12;
    vectors++;
    if (valid !== '0 || xpos !== '0 || kind !== '0 || pass_pulse !== 1'b0 ||
        pass_count !== 8'd0 || running !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_values: got v=%b x=%h k=%b p=%b c=%0d r=%b, expected all zero",
               valid, xpos, kind, pass_pulse, pass_count, running);
    end
    @(negedge clk);
    reset = 1'b0;
    apply_cycle(1'b1, 1'b0, 1'b0, 5'd3, "idle_tick_ignored");
    apply_cycle(1'b0, 1'b1, 1'b1, 5'd0, "idle_start_with_halt");
  endtask

  task automatic test_first_spawn();
    logic [4:0] r;
    logic [4:0] r_last;
    apply_cycle(1'b0, 1'b1, 1'b0, 5'd0, "start");
    apply_cycle(1'b1, 1'b0, 1'b0, 5'd5, "first_spawn");
    vectors++;
    if (valid !== 3'b001 || xpos[9:0] !== 10'd640 || kind[1:0] !== 2'd1) begin
      miscompares++;
      $display("FAIL first_spawn: got v=%b x0=%0d k0=%0d, expected v=001 x0=640 k0=1",
               valid, xpos[9:0], kind[1:0]);
    end
    r_last = '0;
    for (int k = 1; k <= 60; k++) begin
      if ($urandom_range(0, 3) == 0) apply_cycle(1'b0, 1'b0, 1'b0, 5'($urandom), "gap_idle");
      r = 5'($urandom);
      r_last = r;
      apply_cycle(1'b1, 1'b0, 1'b0, r, "gap_tick");
      if (k == 59) begin
        vectors++;
        if (valid[1] !== 1'b0) begin
          miscompares++;
          $display("FAIL gap_early: got valid1=%b, expected 0", valid[1]);
        end
      end
    end
    vectors++;
    if (valid[1] !== 1'b1 || xpos[19:10] !== 10'd640 || kind[3:2] !== r_last[1:0]) begin
      miscompares++;
      $display("FAIL gap_60: got v1=%b x1=%0d k1=%0d, expected v1=1 x1=640 k1=%0d",
               valid[1], xpos[19:10], kind[3:2], r_last[1:0]);
    end
  endtask

  task automatic test_full_slots();
    restart_run();
    for (int k = 1; k <= 323; k++) begin
      apply_cycle(1'b1, 1'b0, 1'b0, 5'd0, "full_tick");
      if (k == 121 && valid !== 3'b111) begin
        miscompares++;
        $display("FAIL full_121: got v=%b, expected 111", valid);
      end
      if (k == 272) begin
        vectors++;
        if (pass_pulse !== 1'b1 || xpos[9:0] !== 10'd98 || pass_count !== 8'd1) begin
          miscompares++;
          $display("FAIL pass_272: got p=%b x0=%0d c=%0d, expected p=1 x0=98 c=1",
                   pass_pulse, xpos[9:0], pass_count);
        end
      end
      if (k == 273 && pass_pulse !== 1'b0) begin
        miscompares++;
        $display("FAIL pass_width: got p=%b, expected 0", pass_pulse);
      end
      if (k == 322) begin
        vectors++;
        if (valid !== 3'b110 || xpos[9:0] !== 10'd0) begin
          miscompares++;
          $display("FAIL retire_322: got v=%b x0=%0d, expected v=110 x0=0", valid, xpos[9:0]);
        end
      end
    end
    vectors += 2;
    if (valid !== 3'b111 || xpos[9:0] !== 10'd640) begin
      miscompares++;
      $display("FAIL respawn_323: got v=%b x0=%0d, expected v=111 x0=640", valid, xpos[9:0]);
    end
  endtask

  task automatic test_halt();
    int exp_x0;
    exp_x0 = m_xpos[0];
    apply_cycle(1'b1, 1'b1, 1'b1, 5'd7, "halt_with_tick");
    vectors++;
    if (xpos[9:0] !== 10'(exp_x0) || running !== 1'b0) begin
      miscompares++;
      $display("FAIL halt_freeze: got x0=%0d run=%b, expected x0=%0d run=0",
               xpos[9:0], running, exp_x0);
    end
    for (int k = 0; k < 5; k++) apply_cycle(1'b1, 1'b0, 1'b0, 5'($urandom), "halted_tick");
    apply_cycle(1'b0, 1'b1, 1'b1, 5'd0, "halted_start_halt");
    apply_cycle(1'b0, 1'b1, 1'b0, 5'd0, "restart");
    vectors++;
    if (valid !== '0 || pass_count !== 8'd0 || running !== 1'b1) begin
      miscompares++;
      $display("FAIL restart_clear: got v=%b c=%0d run=%b, expected v=000 c=0 run=1",
               valid, pass_count, running);
    end
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 50; k++) apply_cycle(1'b1, 1'b0, 1'b0, 5'($urandom), "pre_reset");
    tick = 1'b1;
    #2 reset = 1'b1;
    #1;
    model_reset();
    vectors++;
    if (valid !== '0 || xpos !== '0 || kind !== '0 || pass_pulse !== 1'b0 ||
        pass_count !== 8'd0 || running !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: got v=%b x=%h k=%b p=%b c=%0d r=%b, expected all zero",
               valid, xpos, kind, pass_pulse, pass_count, running);
    end
    @(posedge clk);
    #1;
    compare_model("reset_held");
    @(negedge clk);
    reset = 1'b0;
    apply_cycle(1'b1, 1'b0, 1'b0, 5'd0, "post_reset_idle");
  endtask

  task automatic test_random();
    logic t, s, h;
    apply_cycle(1'b0, 1'b1, 1'b0, 5'd0, "rand_start");
    for (int k = 0; k < 3000; k++) begin
      t = ($urandom_range(0, 99) < 70);
      s = ($urandom_range(0, 99) < 3);
      h = ($urandom_range(0, 199) < 2);
      apply_cycle(t, s, h, 5'($urandom), "random");
    end
  endtask

`ifdef OBSTACLE_SPEEDUP_EN
  task automatic speed_probe(input int min_count, input int exp_dec, input string tag);
    int budget, idx, before;
    budget = 0;
    restart_run();
    while (m_count < min_count && budget < 20000) begin
      apply_cycle(1'b1, 1'b0, 1'b0, 5'd0, "speed_run");
      budget++;
    end
    idx = -1;
    while (idx < 0 && budget < 20000) begin
      for (int i = NS - 1; i >= 0; i--) if (m_valid[i] && m_xpos[i] >= 8) idx = i;
      if (idx < 0) begin apply_cycle(1'b1, 1'b0, 1'b0, 5'd0, "speed_seek"); budget++; end
    end
    vectors++;
    if (budget >= 20000) begin
      miscompares++;
      $display("FAIL %s timeout: got count=%0d, expected >= %0d", tag, pass_count, min_count);
    end else begin
      before = m_xpos[idx];
      apply_cycle(1'b1, 1'b0, 1'b0, 5'd0, tag);
      if (xpos[idx*10 +: 10] !== 10'(before - exp_dec)) begin
        miscompares++;
        $display("FAIL %s: got x=%0d, expected %0d", tag, xpos[idx*10 +: 10], before - exp_dec);
      end
    end
  endtask

  task automatic test_speedup();
    speed_probe(8, 3, "speed_after_8");
    speed_probe(32, 5, "speed_cap_32");
  endtask
`endif

  initial begin
    test_reset();
    test_first_spawn();
    test_full_slots();
    test_halt();
    test_async_reset();
    test_random();
`ifdef OBSTACLE_SPEEDUP_EN
    test_speedup();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
